// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - producer/consumer handshake and decoded-field bundle for decode_stage
interface decode_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_ins;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      out_op;
    logic [4:0]      out_rs;
    logic [4:0]      out_rt;
    logic [4:0]      out_rd;
    logic [4:0]      out_shamt;
    logic [5:0]      out_funct;
    logic [25:0]     out_addr;
    logic [31:0]     out_imm;
    logic [PC_W-1:0] out_pc;
    logic            out_illegal;

    // Producer offers instructions and the consumer drains decoded ones.
    modport master (
        output in_valid, in_ins, in_pc, out_ready,
        input  in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
               out_funct, out_addr, out_imm, out_pc, out_illegal
    );

    // The decode stage itself.
    modport slave (
        input  in_valid, in_ins, in_pc, out_ready,
        output in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
               out_funct, out_addr, out_imm, out_pc, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode at push time into a circular FIFO; optional DECODE_ILLEGAL_TRAP_EN per-entry illegal-opcode flag
module decode_stage #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    decode_stage_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [5:0]      op;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      funct;
        logic [25:0]     addr;
        logic [31:0]     imm;
        logic [PC_W-1:0] pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic            illegal;
`endif
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    entry_t           w_dec;
    entry_t           w_head;
    logic             w_full;
    logic             w_valid;
    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;

`ifdef DECODE_ILLEGAL_TRAP_EN
    function automatic logic is_illegal(input logic [5:0] op);
        case (op)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: is_illegal = 1'b0;
            default:                                   is_illegal = 1'b1;
        endcase
    endfunction
`endif

    // Full blocks push even when a pop happens this cycle, so in_ready never sees out_ready.
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_valid    = (r_count != '0);
    assign w_in_ready = !w_full && !rst;
    assign w_push     = bus.in_valid && w_in_ready && !flush;
    assign w_pop      = w_valid && bus.out_ready && !flush;
    assign w_head     = r_mem[r_rd_ptr];

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid;

    // Split the raw word into fields and build the immediate before it is queued.
    always_comb begin
        w_dec       = '0;
        w_dec.op    = bus.in_ins[31:26];
        w_dec.rs    = bus.in_ins[25:21];
        w_dec.rt    = bus.in_ins[20:16];
        w_dec.rd    = bus.in_ins[15:11];
        w_dec.shamt = bus.in_ins[10:6];
        w_dec.funct = bus.in_ins[5:0];
        w_dec.addr  = bus.in_ins[25:0];
        w_dec.pc    = bus.in_pc;
        case (bus.in_ins[31:26])
            6'h0C, 6'h0D, 6'h0E: w_dec.imm = {16'h0000, bus.in_ins[15:0]};
            6'h0F:               w_dec.imm = {bus.in_ins[15:0], 16'h0000};
            default:             w_dec.imm = {{16{bus.in_ins[15]}}, bus.in_ins[15:0]};
        endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
        w_dec.illegal = is_illegal(bus.in_ins[31:26]);
`endif
    end

    // Pointer and occupancy bookkeeping; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Entry storage is left unreset; the output mask hides stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    // Present the head entry, forcing every field to zero while the queue is empty.
    always_comb begin
        bus.out_op      = '0;
        bus.out_rs      = '0;
        bus.out_rt      = '0;
        bus.out_rd      = '0;
        bus.out_shamt   = '0;
        bus.out_funct   = '0;
        bus.out_addr    = '0;
        bus.out_imm     = '0;
        bus.out_pc      = '0;
        bus.out_illegal = 1'b0;
        if (w_valid) begin
            bus.out_op    = w_head.op;
            bus.out_rs    = w_head.rs;
            bus.out_rt    = w_head.rt;
            bus.out_rd    = w_head.rd;
            bus.out_shamt = w_head.shamt;
            bus.out_funct = w_head.funct;
            bus.out_addr  = w_head.addr;
            bus.out_imm   = w_head.imm;
            bus.out_pc    = w_head.pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
            bus.out_illegal = w_head.illegal;
`endif
        end
    end
endmodule
